// File: rtl/pong_match_if.sv
// Game-side bundle of the pong match controller: frame strobe, buttons, ball/paddle
// positions in; FSM state, object enables, hit pulses and scores out.
interface pong_match_if #(
    parameter int unsigned FIELD_W = 64,
    parameter int unsigned FIELD_H = 32,
    parameter int unsigned SCORE_W = 4
);
    localparam int unsigned XW = $clog2(FIELD_W);
    localparam int unsigned YW = $clog2(FIELD_H);

    logic               tick;
    logic               start_n;
    logic               play_again_n;
    logic               pause_n;
    logic               mode_pvp;
    logic [XW-1:0]      ball_x;
    logic [YW-1:0]      ball_y;
    logic               ball_step;
    logic [YW-1:0]      left_pad_y;
    logic [YW-1:0]      right_pad_y;
    logic [2:0]         state;
    logic               objs_rst_n;
    logic               run;
    logic               hit_left;
    logic               hit_right;
    logic [SCORE_W-1:0] left_score;
    logic [SCORE_W-1:0] right_score;
    logic [1:0]         winner;

    modport master (
        output tick, start_n, play_again_n, pause_n, mode_pvp,
               ball_x, ball_y, ball_step, left_pad_y, right_pad_y,
        input  state, objs_rst_n, run, hit_left, hit_right,
               left_score, right_score, winner
    );

    modport slave (
        input  tick, start_n, play_again_n, pause_n, mode_pvp,
               ball_x, ball_y, ball_step, left_pad_y, right_pad_y,
        output state, objs_rst_n, run, hit_left, hit_right,
               left_score, right_score, winner
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match controller: start/serve/rally/point/game-over sequencing, paddle
// collision detection, scoring with optional win-by-two, object reset/run enables.
module pong_match_ctrl #(
    parameter int unsigned FIELD_W     = 64,
    parameter int unsigned FIELD_H     = 32,
    parameter int unsigned PAD_H       = 4,
    parameter int unsigned SCORE_W     = 4,
    parameter int unsigned WIN_SCORE   = 11,
    parameter int unsigned WIN_BY_TWO  = 0,
    parameter int unsigned SERVE_TICKS = 30
) (
    input  logic        clk,
    input  logic        reset,
    pong_match_if.slave bus
);
    localparam int unsigned XW  = $clog2(FIELD_W);
    localparam int unsigned YW  = $clog2(FIELD_H);
    localparam int unsigned YW1 = YW + 1;
    localparam int unsigned CW  = $clog2(SERVE_TICKS + 1);
    localparam int unsigned SW1 = SCORE_W + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        POINT = 3'd4,
        OVER  = 3'd5
    } stateT;

    stateT              state;
    stateT              nextState;
    logic [CW-1:0]      serveCnt;
    logic               modePvp;
    logic               pausePrev;
    logic               pausePend;
    logic               pausePendNext;
    logic [SCORE_W-1:0] leftScore;
    logic [SCORE_W-1:0] rightScore;
    logic [1:0]         winner;
    logic               hitLeft;
    logic               hitRight;
    logic               objsRstN;
    logic               run;
    logic               objsRstNNext;
    logic               runNext;

    function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + SCORE_W'(1);
    endfunction

    // Paddle windows are computed one bit wider so a paddle near the bottom edge does not wrap
    logic [YW1-1:0] ballY1;
    logic [YW1-1:0] leftTop;
    logic [YW1-1:0] rightTop;
    logic [YW1-1:0] leftBot;
    logic [YW1-1:0] rightBot;
    logic           inLeft;
    logic           inRight;
    logic           atLeft;
    logic           atRight;
    logic           strike;
    logic           hitL;
    logic           hitR;
    logic           miss;

    assign ballY1   = {1'b0, bus.ball_y};
    assign leftTop  = {1'b0, bus.left_pad_y};
    assign rightTop = {1'b0, bus.right_pad_y};
    assign leftBot  = leftTop + YW1'(PAD_H - 1);
    assign rightBot = rightTop + YW1'(PAD_H - 1);
    assign inLeft   = (ballY1 >= leftTop) && (ballY1 <= leftBot);
    assign inRight  = (ballY1 >= rightTop) && (ballY1 <= rightBot);
    assign atLeft   = (bus.ball_x == XW'(1));
    assign atRight  = (bus.ball_x >= XW'(FIELD_W - 2));
    assign strike   = bus.tick && bus.ball_step && (state == PLAY) && (atLeft || atRight);
    assign hitL     = strike && atLeft && inLeft;
    assign hitR     = strike && !atLeft && atRight && inRight;
    assign miss     = strike && !hitL && !hitR;

    logic [SW1-1:0] left1;
    logic [SW1-1:0] right1;
    logic           leftWins;
    logic           rightWins;

    assign left1     = {1'b0, leftScore};
    assign right1    = {1'b0, rightScore};
    assign leftWins  = (left1 >= SW1'(WIN_SCORE)) &&
                       ((WIN_BY_TWO == 0) || (left1 >= right1 + SW1'(2)));
    assign rightWins = (right1 >= SW1'(WIN_SCORE)) &&
                       ((WIN_BY_TWO == 0) || (right1 >= left1 + SW1'(2)));

    // Pause edges are caught every clk and held until the next tick in PLAY/PAUSE
    logic pauseFall;
    logic pauseReq;

    assign pauseFall = pausePrev & ~bus.pause_n;
    assign pauseReq  = pausePend | pauseFall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState     = state;
        pausePendNext = 1'b0;
        case (state)
            IDLE:  if (bus.tick && !bus.start_n) nextState = SERVE;
            SERVE: if (bus.tick && (serveCnt == CW'(SERVE_TICKS - 1))) nextState = PLAY;
            PLAY: begin
                if (miss) begin
                    nextState = modePvp ? POINT : OVER;
                end else if (bus.tick && !strike && pauseReq) begin
                    nextState = PAUSE;
                end
            end
            PAUSE: if (bus.tick && pauseReq) nextState = PLAY;
            POINT: begin
                if (bus.tick) begin
                    nextState = (leftWins || rightWins) ? OVER : SERVE;
                end
            end
            OVER:  if (bus.tick && !bus.play_again_n) nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (((state == PLAY) || (state == PAUSE)) && (nextState == state)) begin
            pausePendNext = pauseReq;
        end
    end

    always_comb begin
        objsRstNNext = 1'b1;
        runNext      = 1'b0;
        case (nextState)
            IDLE, POINT, OVER: objsRstNNext = 1'b0;
            PLAY:              runNext      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            serveCnt   <= '0;
            modePvp    <= 1'b0;
            pausePrev  <= 1'b1;
            pausePend  <= 1'b0;
            leftScore  <= '0;
            rightScore <= '0;
            winner     <= 2'b00;
            hitLeft    <= 1'b0;
            hitRight   <= 1'b0;
            objsRstN   <= 1'b0;
            run        <= 1'b0;
        end else begin
            pausePrev <= bus.pause_n;
            pausePend <= pausePendNext;
            hitLeft   <= hitL;
            hitRight  <= hitR;
            objsRstN  <= objsRstNNext;
            run       <= runNext;
            if (state != SERVE) begin
                serveCnt <= '0;
            end else if (bus.tick) begin
                serveCnt <= serveCnt + CW'(1);
            end
            if ((state == IDLE) && bus.tick && !bus.start_n) begin
                modePvp <= bus.mode_pvp;
            end
            if (nextState == IDLE) begin
                leftScore  <= '0;
                rightScore <= '0;
                winner     <= 2'b00;
            end else begin
                if ((hitL || hitR) && !modePvp) leftScore <= satInc(leftScore);
                if (miss && modePvp) begin
                    if (atLeft) rightScore <= satInc(rightScore);
                    else        leftScore  <= satInc(leftScore);
                end
                if (miss && !modePvp) winner <= 2'b01;
                if ((state == POINT) && bus.tick) begin
                    if (leftWins)       winner <= 2'b01;
                    else if (rightWins) winner <= 2'b10;
                end
            end
        end
    end

    assign bus.state       = state;
    assign bus.objs_rst_n  = objsRstN;
    assign bus.run         = run;
    assign bus.hit_left    = hitLeft;
    assign bus.hit_right   = hitRight;
    assign bus.left_score  = leftScore;
    assign bus.right_score = rightScore;
    assign bus.winner      = winner;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: two instances (plain win and win-by-two) share
// stimulus; hit pulses are checked against a queue of expected hits.
module tb_pong_match_ctrl;
    localparam logic [2:0] sIdle  = 3'd0;
    localparam logic [2:0] sServe = 3'd1;
    localparam logic [2:0] sPlay  = 3'd2;
    localparam logic [2:0] sPause = 3'd3;
    localparam logic [2:0] sPoint = 3'd4;
    localparam logic [2:0] sOver  = 3'd5;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       tick       = 1'b1;
    logic       startN     = 1'b1;
    logic       playAgainN = 1'b1;
    logic       pauseN     = 1'b1;
    logic       modePvp    = 1'b1;
    logic       ballStep   = 1'b0;
    logic [5:0] ballX      = 6'd32;
    logic [4:0] ballY      = 5'd0;
    logic [4:0] leftPadY   = 5'd0;
    logic [4:0] rightPadY  = 5'd0;

    int checks = 0;
    int failures = 0;
    int expL = 0;
    int expR = 0;
    int hitsPushed = 0;
    int hitsSeen = 0;
    bit overA = 1'b0;
    bit overB = 1'b0;
    logic [1:0] expHits[$];

    pong_match_if ifA ();
    pong_match_if ifB ();

    assign ifA.tick = tick;          assign ifB.tick = tick;
    assign ifA.start_n = startN;     assign ifB.start_n = startN;
    assign ifA.play_again_n = playAgainN; assign ifB.play_again_n = playAgainN;
    assign ifA.pause_n = pauseN;     assign ifB.pause_n = pauseN;
    assign ifA.mode_pvp = modePvp;   assign ifB.mode_pvp = modePvp;
    assign ifA.ball_x = ballX;       assign ifB.ball_x = ballX;
    assign ifA.ball_y = ballY;       assign ifB.ball_y = ballY;
    assign ifA.ball_step = ballStep; assign ifB.ball_step = ballStep;
    assign ifA.left_pad_y = leftPadY;   assign ifB.left_pad_y = leftPadY;
    assign ifA.right_pad_y = rightPadY; assign ifB.right_pad_y = rightPadY;

    pong_match_ctrl dutA (.clk(clk), .reset(reset), .bus(ifA));
    pong_match_ctrl #(.WIN_BY_TWO(1)) dutB (.clk(clk), .reset(reset), .bus(ifB));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkDut(input bit useB, input string tag, input logic [2:0] st);
        check({tag, "_state"},  32'(useB ? ifB.state : ifA.state), 32'(st));
        check({tag, "_lscore"}, 32'(useB ? ifB.left_score : ifA.left_score), 32'(expL));
        check({tag, "_rscore"}, 32'(useB ? ifB.right_score : ifA.right_score), 32'(expR));
    endtask

    // Hit pulses from dutA are matched in order against the expected-hit queue
    always @(negedge clk) begin
        logic [1:0] exp;
        if (reset === 1'b1 && (ifA.hit_left === 1'b1 || ifA.hit_right === 1'b1)) begin
            hitsSeen++;
            exp = (expHits.size() == 0) ? 2'b00 : expHits.pop_front();
            check("hit_pulse", 32'({ifA.hit_right, ifA.hit_left}), 32'(exp));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic startGame(input bit pvp);
        modePvp = pvp;
        startN = 1'b0;
        cyc;
        checkDut(0, "start", sServe);
        check("start_objs", 32'(ifA.objs_rst_n), 1);
        check("start_run", 32'(ifA.run), 0);
        startN = 1'b1;
        modePvp = !pvp;
        pauseN = 1'b0;
        cyc;
        pauseN = 1'b1;
        repeat (28) cyc;
        checkDut(0, "serve29", sServe);
        cyc;
        checkDut(0, "serve30_A", sPlay);
        checkDut(1, "serve30_B", sPlay);
        check("serve30_run", 32'(ifA.run), 1);
    endtask

    task automatic hitAt(input bit left, input logic [4:0] padY, input logic [4:0] bY, input bit practice);
        if (left) begin leftPadY = padY; ballX = 6'd1; end
        else begin rightPadY = padY; ballX = 6'd62; end
        ballY = bY;
        ballStep = 1'b1;
        expHits.push_back(left ? 2'b01 : 2'b10);
        hitsPushed++;
        cyc;
        ballStep = 1'b0;
        ballX = 6'd32;
        if (practice && expL < 15) expL++;
        checkDut(0, "hit_A", sPlay);
        checkDut(1, "hit_B", sPlay);
    endtask

    task automatic scorePoint(input bit leftScores, input logic [4:0] padY, input logic [4:0] bY);
        bit winA;
        bit winB;
        leftPadY = padY;
        rightPadY = padY;
        ballY = bY;
        ballX = leftScores ? 6'd63 : 6'd1;
        ballStep = 1'b1;
        cyc;
        ballStep = 1'b0;
        ballX = 6'd32;
        if (leftScores) expL++; else expR++;
        if (!overA) checkDut(0, "miss_A", sPoint);
        if (!overB) checkDut(1, "miss_B", sPoint);
        if (!overA) check("point_objs", 32'(ifA.objs_rst_n), 0);
        cyc;
        winA = (expL >= 11) || (expR >= 11);
        winB = (expL >= 11 && expL >= expR + 2) || (expR >= 11 && expR >= expL + 2);
        if (!overA) begin
            checkDut(0, "wincheck_A", winA ? sOver : sServe);
            if (winA) check("winner_A", 32'(ifA.winner), (expL >= 11) ? 1 : 2);
            overA = winA;
        end
        if (!overB) begin
            checkDut(1, "wincheck_B", winB ? sOver : sServe);
            if (winB) check("winner_B", 32'(ifB.winner), (expL >= 11) ? 1 : 2);
            overB = winB;
        end
        if (!overA || !overB) begin
            repeat (29) cyc;
            if (!overB) checkDut(1, "reserve_B", sServe);
            cyc;
            if (!overA) checkDut(0, "replay_A", sPlay);
            if (!overB) checkDut(1, "replay_B", sPlay);
        end
    endtask

    task automatic playAgain;
        playAgainN = 1'b0;
        cyc;
        playAgainN = 1'b1;
        expL = 0;
        expR = 0;
        overA = 1'b0;
        overB = 1'b0;
        checkDut(0, "again_A", sIdle);
        checkDut(1, "again_B", sIdle);
        check("again_winner", 32'(ifA.winner), 0);
    endtask

    initial begin
        repeat (2) cyc;
        checkDut(0, "reset", sIdle);
        check("reset_objs", 32'(ifA.objs_rst_n), 0);
        check("reset_run", 32'(ifA.run), 0);
        check("reset_hits", 32'({ifA.hit_right, ifA.hit_left}), 0);
        check("reset_winner", 32'(ifA.winner), 0);
        reset = 1'b1;
        cyc;

        // No transition without a tick
        tick = 1'b0;
        startN = 1'b0;
        cyc;
        checkDut(0, "tick_gate", sIdle);
        tick = 1'b1;
        startN = 1'b1;

        startGame(1);
        hitAt(1, 5'd10, 5'd13, 0);
        scorePoint(0, 5'd10, 5'd14);

        repeat (4) scorePoint(0, 5'd0, 5'd20);
        repeat (11) scorePoint(1, 5'd0, 5'd20);
        playAgain;

        // 10-10, then 11-10 (plain wins, by-two continues), then 12-10
        startGame(1);
        for (int i = 0; i < 10; i++) begin
            scorePoint(1, 5'd0, 5'd20);
            scorePoint(0, 5'd0, 5'd20);
        end
        scorePoint(1, 5'd0, 5'd20);
        scorePoint(1, 5'd0, 5'd20);
        playAgain;

        startGame(0);
        hitAt(1, 5'd10, 5'd12, 1);
        hitAt(0, 5'd5, 5'd5, 1);
        hitAt(0, 5'd5, 5'd8, 1);
        ballX = 6'd63;
        rightPadY = 5'd0;
        ballY = 5'd20;
        ballStep = 1'b1;
        cyc;
        ballStep = 1'b0;
        ballX = 6'd32;
        checkDut(0, "practice_A", sOver);
        checkDut(1, "practice_B", sOver);
        check("practice_winner", 32'(ifA.winner), 1);
        check("practice_objs", 32'(ifA.objs_rst_n), 0);
        check("practice_run", 32'(ifA.run), 0);
        playAgain;

        startGame(1);
        cyc;
        checkDut(0, "serve_pause_ignored", sPlay);
        tick = 1'b0;
        pauseN = 1'b0;
        cyc;
        checkDut(0, "pause_gated", sPlay);
        tick = 1'b1;
        pauseN = 1'b1;
        cyc;
        checkDut(0, "pause_enter", sPause);
        check("pause_run", 32'(ifA.run), 0);
        check("pause_objs", 32'(ifA.objs_rst_n), 1);
        repeat (3) cyc;
        checkDut(0, "pause_hold", sPause);
        check("pause_hold_run", 32'(ifA.run), 0);
        pauseN = 1'b0;
        cyc;
        pauseN = 1'b1;
        checkDut(0, "pause_exit", sPlay);
        check("pause_exit_run", 32'(ifA.run), 1);
        cyc;
        checkDut(0, "pause_stay", sPlay);

        // Hit and pause on the same tick: hit first, pause one tick later
        pauseN = 1'b0;
        hitAt(1, 5'd10, 5'd10, 0);
        pauseN = 1'b1;
        cyc;
        checkDut(0, "pause_after_hit", sPause);
        pauseN = 1'b0;
        cyc;
        pauseN = 1'b1;
        checkDut(0, "pause_after_hit_exit", sPlay);

        // Miss and pause on the same tick: the pause is dropped
        pauseN = 1'b0;
        scorePoint(1, 5'd0, 5'd20);
        pauseN = 1'b1;
        cyc;
        checkDut(0, "miss_beats_pause", sPlay);

        // Async reset with a hit about to register
        ballX = 6'd1;
        leftPadY = 5'd10;
        ballY = 5'd12;
        ballStep = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        expL = 0;
        expR = 0;
        checkDut(0, "async_reset", sIdle);
        check("async_objs", 32'(ifA.objs_rst_n), 0);
        check("async_run", 32'(ifA.run), 0);
        check("async_winner", 32'(ifA.winner), 0);
        cyc;
        check("async_no_hit", 32'({ifA.hit_right, ifA.hit_left}), 0);
        checkDut(0, "async_hold", sIdle);
        ballStep = 1'b0;
        ballX = 6'd32;
        reset = 1'b1;
        cyc;

        startGame(1);
        hitAt(0, 5'd30, 5'd31, 0);
        scorePoint(1, 5'd30, 5'd29);

        check("hit_queue_empty", 32'(expHits.size()), 0);
        check("hit_count", 32'(hitsSeen), 32'(hitsPushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
